apb_timer_slave: RTL and testbench
==================================

# apb_timer_slave

APB responder implementing a 32-bit down-counting timer peripheral with interrupt, sitting behind the APB mux on the timer select line. It decodes a small register file, applies byte-strobed writes, inserts a parameterised number of wait states, and flags illegal accesses with PSLVERR. It is the peripheral end answering transfers issued by the APB master.

## Interface
- ADDR_WIDTH, 32, PADDR width; only PADDR[4:0] decoded, upper bits ignored.
- DATA_WIDTH, 32, PWDATA/PRDATA width; fixed at 32 for this block.
- WAIT_STATES, 1, access-phase cycles with PREADY low before completion (0–15).

Ports:
- PCLK  in  1  clock, all logic rising-edge.
- PRESET  in  1  asynchronous, active-high reset.
- PSEL  in  1  slave select from mux.
- PENABLE  in  1  access-phase indicator.
- PWRITE  in  1  1 = write, 0 = read.
- PADDR  in  ADDR_WIDTH  byte address.
- PWDATA  in  DATA_WIDTH  write data.
- PSTRB  in  DATA_WIDTH/8  write byte lanes.
- PRDATA  out  DATA_WIDTH  read data, valid while PREADY=1.
- PREADY  out  1  transfer completion.
- PSLVERR  out  1  error response, valid while PREADY=1.
- irq  out  1  registered interrupt request, level.

## Operation
- Register map (offset): 0x00 CTRL {bit0 EN, bit1 RELOAD, bit2 IRQ_EN}; 0x04 LOAD; 0x08 COUNT (RO); 0x0C STATUS {bit0 EXP, write-1-to-clear}; 0x10 PRESCALE[7:0] (macro only).
- Reset values: CTRL 0, LOAD 0, COUNT 0, STATUS 0, PRESCALE 0; outputs PRDATA 0, PREADY 0, PSLVERR 0, irq 0.
- Bus FSM: IDLE → ACCESS when PSEL=1 (setup cycle); wait counter cleared. In ACCESS with PENABLE=1, counter increments each cycle; PREADY=1 when counter == WAIT_STATES, for exactly one cycle; then back to IDLE (or stay, re-entering setup, if PSEL remains and PENABLE=0).
- Write commits on the PREADY=1 edge only, per PSTRB lane; PSTRB=0 is a legal no-op.
- Writing LOAD while EN=0 also copies LOAD into COUNT; while EN=1 COUNT untouched.
- PSLVERR=1 (no state change, PRDATA=0) for: unmapped offset, PADDR[1:0]≠0, write to COUNT.
- Counter: when EN=1 and tick, COUNT decrements. Tick on COUNT=0: EXP set; RELOAD=1 → COUNT←LOAD; RELOAD=0 → EN cleared, COUNT stays 0.
- irq registered: irq ← EXP & IRQ_EN.
- Simultaneous EXP set and W1C in same cycle: set wins, EXP stays 1.
- Simultaneous CTRL write and expiry clearing EN: bus write wins.

## Timing
- Read/write latency: setup + (WAIT_STATES+1) access cycles; WAIT_STATES=0 gives zero-wait APB.
- PRDATA/PSLVERR driven combinationally from decoded registers in the PREADY cycle; 0 otherwise.
- irq asserts one cycle after EXP sets; drops one cycle after EXP or IRQ_EN cleared.
- COUNT read reflects value before the current-cycle decrement.
- PRESET mid-transfer: FSM to IDLE, PREADY 0, pending write discarded, all registers to reset values asynchronously.
- PSEL deasserted mid-access (protocol violation): FSM returns to IDLE, no commit.

## Configuration
- APB_TIMER_PRESCALER_EN defined: PRESCALE register at 0x10 present; tick pulses once every PRESCALE+1 cycles via 8-bit prescale counter, counter cleared when EN=0 or PRESCALE written.
- Undefined: tick = every cycle while EN=1; 0x10 unmapped (PSLVERR).

## Test plan
- WAIT_STATES=1: write 0x0000_00A5 to LOAD, read back → PREADY high on 2nd access cycle, PRDATA=0x0000_00A5, PSLVERR=0.
- LOAD=3, CTRL=0x7 → COUNT 3,2,1,0 then EXP=1, COUNT reloads 3, irq high one cycle after EXP.
- LOAD=2, CTRL=0x1 (one-shot) → after expiry EN reads 0, COUNT=0, irq stays 0; W1C STATUS → EXP=0.
- Write COUNT, read 0x14, access 0x06 → each PSLVERR=1, PRDATA=0, no register change.
- PSTRB=4'b0010 write 0xDEAD_BEEF to LOAD from 0 → LOAD=0x0000_BE00.
- PRESET asserted during access phase of a LOAD write → PREADY 0 immediately, LOAD=0 after reset.

Source files
------------

// File: rtl/apb_timer_slave.sv
// apb_timer_slave
// APB responder for a 32-bit down-counting timer with a level interrupt.
// Register map: 0x00 CTRL {IRQ_EN, RELOAD, EN}, 0x04 LOAD, 0x08 COUNT (read-only),
// 0x0C STATUS {EXP, write-1-to-clear}.
// Optional feature macro: APB_TIMER_PRESCALER_EN adds PRESCALE[7:0] at 0x10 and an
// 8-bit prescaler so the timer ticks once every PRESCALE+1 cycles. Without it the
// timer ticks every cycle while enabled and 0x10 answers with PSLVERR.
module apb_timer_slave #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int WAIT_STATES = 1
) (
    input  logic                    PCLK,
    input  logic                    PRESET,
    input  logic                    PSEL,
    input  logic                    PENABLE,
    input  logic                    PWRITE,
    input  logic [ADDR_WIDTH-1:0]   PADDR,
    input  logic [DATA_WIDTH-1:0]   PWDATA,
    input  logic [DATA_WIDTH/8-1:0] PSTRB,
    output logic [DATA_WIDTH-1:0]   PRDATA,
    output logic                    PREADY,
    output logic                    PSLVERR,
    output logic                    irq
);

    localparam logic [4:0] OFF_CTRL     = 5'h00;
    localparam logic [4:0] OFF_LOAD     = 5'h04;
    localparam logic [4:0] OFF_COUNT    = 5'h08;
    localparam logic [4:0] OFF_STATUS   = 5'h0C;
`ifdef APB_TIMER_PRESCALER_EN
    localparam logic [4:0] OFF_PRESCALE = 5'h10;
`endif

    // Access-phase cycles spent with PREADY low before completion (0..15).
    localparam logic [3:0] WAIT_LIM = 4'(WAIT_STATES);

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } bus_state_t;

    bus_state_t            state_q;
    bus_state_t            state_d;
    logic [3:0]            wait_cnt_q;
    logic [3:0]            wait_cnt_d;

    logic [4:0]            offset;
    logic                  addr_hit;
    logic                  access_err;
    logic                  wr_commit;
    logic                  ctrl_wr;
    logic                  load_wr;
    logic                  status_wr;
    logic [DATA_WIDTH-1:0] load_wdata;
    logic [DATA_WIDTH-1:0] rd_data;

    logic                  ctrl_en;
    logic                  ctrl_reload;
    logic                  ctrl_irq_en;
    logic [DATA_WIDTH-1:0] load_reg;
    logic [DATA_WIDTH-1:0] count_reg;
    logic                  exp_flag;
    logic                  tick;
    logic                  expire;

    // Only the low five address bits select a register; the rest are ignored.
    logic                  unused_upper_addr;
    assign unused_upper_addr = ^PADDR[ADDR_WIDTH-1:5];

    // Replace the enabled byte lanes of old_val with those of new_val.
    function automatic logic [DATA_WIDTH-1:0] merge_bytes(
        input logic [DATA_WIDTH-1:0]   old_val,
        input logic [DATA_WIDTH-1:0]   new_val,
        input logic [DATA_WIDTH/8-1:0] strb
    );
        logic [DATA_WIDTH-1:0] res;
        res = old_val;
        for (int i = 0; i < DATA_WIDTH / 8; i++) begin
            if (strb[i]) begin
                res[8*i +: 8] = new_val[8*i +: 8];
            end
        end
        return res;
    endfunction

    // Bus state and wait counter registers.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state_q    <= ST_IDLE;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    // Bus sequencing: setup moves to ACCESS, wait states counted, one-cycle PREADY.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        PREADY     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                wait_cnt_d = '0;
                if (PSEL) begin
                    state_d = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if (!PSEL) begin
                    // Master dropped the select mid-transfer: abandon without commit.
                    state_d    = ST_IDLE;
                    wait_cnt_d = '0;
                end else if (!PENABLE) begin
                    // Select held without enable: treat as a fresh setup cycle.
                    wait_cnt_d = '0;
                end else if (wait_cnt_q == WAIT_LIM) begin
                    PREADY     = 1'b1;
                    state_d    = ST_IDLE;
                    wait_cnt_d = '0;
                end else begin
                    wait_cnt_d = wait_cnt_q + 4'd1;
                end
            end
            default: begin
                state_d    = ST_IDLE;
                wait_cnt_d = '0;
            end
        endcase
    end

    assign offset = PADDR[4:0];

    // Address decode: misaligned offsets never match an entry and so are unmapped.
    always_comb begin
        addr_hit = 1'b0;
        case (offset)
            OFF_CTRL, OFF_LOAD, OFF_COUNT, OFF_STATUS: addr_hit = 1'b1;
`ifdef APB_TIMER_PRESCALER_EN
            OFF_PRESCALE: addr_hit = 1'b1;
`endif
            default: addr_hit = 1'b0;
        endcase
    end

    assign access_err = !addr_hit || (PADDR[1:0] != 2'b00) ||
                        (PWRITE && (offset == OFF_COUNT));
    assign wr_commit  = PREADY && PWRITE && !access_err;
    assign ctrl_wr    = wr_commit && (offset == OFF_CTRL);
    assign load_wr    = wr_commit && (offset == OFF_LOAD);
    assign status_wr  = wr_commit && (offset == OFF_STATUS);
    assign load_wdata = merge_bytes(load_reg, PWDATA, PSTRB);

`ifdef APB_TIMER_PRESCALER_EN
    logic       prescale_wr;
    logic [7:0] prescale_reg;
    logic [7:0] pre_cnt;

    assign prescale_wr = wr_commit && (offset == OFF_PRESCALE);

    // PRESCALE register, written through byte lane 0.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            prescale_reg <= '0;
        end else if (prescale_wr && PSTRB[0]) begin
            prescale_reg <= PWDATA[7:0];
        end
    end

    // Prescale counter restarts whenever the timer is off or the divider changes.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            pre_cnt <= '0;
        end else if (!ctrl_en || prescale_wr || (pre_cnt == prescale_reg)) begin
            pre_cnt <= '0;
        end else begin
            pre_cnt <= pre_cnt + 8'd1;
        end
    end

    assign tick = ctrl_en && (pre_cnt == prescale_reg);
`else
    assign tick = ctrl_en;
`endif

    assign expire = tick && (count_reg == '0);

    // CTRL: a bus write takes priority over a one-shot expiry clearing EN.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            ctrl_en     <= 1'b0;
            ctrl_reload <= 1'b0;
            ctrl_irq_en <= 1'b0;
        end else if (ctrl_wr) begin
            if (PSTRB[0]) begin
                ctrl_en     <= PWDATA[0];
                ctrl_reload <= PWDATA[1];
                ctrl_irq_en <= PWDATA[2];
            end
        end else if (expire && !ctrl_reload) begin
            ctrl_en <= 1'b0;
        end
    end

    // LOAD register with byte-lane writes.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            load_reg <= '0;
        end else if (load_wr) begin
            load_reg <= load_wdata;
        end
    end

    // COUNT: preset from LOAD writes while stopped, otherwise decrements per tick.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            count_reg <= '0;
        end else if (load_wr && !ctrl_en) begin
            count_reg <= load_wdata;
        end else if (tick) begin
            if (count_reg == '0) begin
                if (ctrl_reload) begin
                    count_reg <= load_reg;
                end
            end else begin
                count_reg <= count_reg - DATA_WIDTH'(1);
            end
        end
    end

    // STATUS.EXP: an expiry in the same cycle as a clear leaves the flag set.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            exp_flag <= 1'b0;
        end else if (expire) begin
            exp_flag <= 1'b1;
        end else if (status_wr && PSTRB[0] && PWDATA[0]) begin
            exp_flag <= 1'b0;
        end
    end

    // Registered interrupt request.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            irq <= 1'b0;
        end else begin
            irq <= exp_flag && ctrl_irq_en;
        end
    end

    // Read data selection from the current register contents.
    always_comb begin
        rd_data = '0;
        case (offset)
            OFF_CTRL:     rd_data = {{(DATA_WIDTH-3){1'b0}}, ctrl_irq_en, ctrl_reload, ctrl_en};
            OFF_LOAD:     rd_data = load_reg;
            OFF_COUNT:    rd_data = count_reg;
            OFF_STATUS:   rd_data = {{(DATA_WIDTH-1){1'b0}}, exp_flag};
`ifdef APB_TIMER_PRESCALER_EN
            OFF_PRESCALE: rd_data = {{(DATA_WIDTH-8){1'b0}}, prescale_reg};
`endif
            default:      rd_data = '0;
        endcase
    end

    assign PRDATA  = (PREADY && !PWRITE && !access_err) ? rd_data : '0;
    assign PSLVERR = PREADY && access_err;

endmodule

// File: tb/tb_apb_timer_slave.sv
// Self-checking bench for apb_timer_slave with WAIT_STATES=1.
// The timer reference model predicts COUNT/EXP/EN/irq arithmetically from the
// number of clock edges since the timer was started.
module tb_apb_timer_slave;

    localparam int WS = 1;
    localparam logic [31:0] A_CTRL   = 32'h00;
    localparam logic [31:0] A_LOAD   = 32'h04;
    localparam logic [31:0] A_COUNT  = 32'h08;
    localparam logic [31:0] A_STATUS = 32'h0C;

    logic        PCLK;
    logic        PRESET;
    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [31:0] PADDR;
    logic [31:0] PWDATA;
    logic [3:0]  PSTRB;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;
    logic        irq;

    int n_compared   = 0;
    int n_mismatched = 0;
    int cyc          = 0;
    int last_sample  = 0;

    // Reference model state
    logic [31:0] m_load;
    logic [31:0] m_count_static;
    bit          m_running;
    bit          m_reload;
    bit          m_irq_en;
    bit          m_exp_static;
    int          m_start;

    apb_timer_slave #(
        .ADDR_WIDTH (32),
        .DATA_WIDTH (32),
        .WAIT_STATES(WS)
    ) dut (
        .PCLK   (PCLK),
        .PRESET (PRESET),
        .PSEL   (PSEL),
        .PENABLE(PENABLE),
        .PWRITE (PWRITE),
        .PADDR  (PADDR),
        .PWDATA (PWDATA),
        .PSTRB  (PSTRB),
        .PRDATA (PRDATA),
        .PREADY (PREADY),
        .PSLVERR(PSLVERR),
        .irq    (irq)
    );

    initial begin
        PCLK = 1'b0;
        forever #5 PCLK = ~PCLK;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        n_compared++;
        assert (observed === expected)
        else begin
            n_mismatched++;
            $error("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge PCLK);
        cyc++;
        #1;
    endtask

    // One complete APB transfer; returns at 1ns after the completing edge.
    task automatic applyStimulus(input bit write, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic [3:0] strb,
                                 output logic [31:0] rdata, output logic slverr);
        int n;
        PSEL    = 1'b1;
        PENABLE = 1'b0;
        PWRITE  = write;
        PADDR   = addr;
        PWDATA  = wdata;
        PSTRB   = strb;
        step();
        PENABLE = 1'b1;
        #1;
        n = 1;
        while (PREADY !== 1'b1 && n <= 20) begin
            step();
            n++;
        end
        checkOutput("latency", 32'(n), 32'(WS + 1));
        rdata       = PRDATA;
        slverr      = PSLVERR;
        last_sample = cyc;
        step();
        PSEL    = 1'b0;
        PENABLE = 1'b0;
        PWRITE  = 1'b0;
        PSTRB   = 4'h0;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                      input string tag);
        logic [31:0] r;
        logic        e;
        applyStimulus(1'b1, a, d, s, r, e);
        checkOutput({tag, "_slverr"}, 32'(e), 32'h0);
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d, input string tag);
        logic e;
        applyStimulus(1'b0, a, 32'h0, 4'h0, d, e);
        checkOutput({tag, "_slverr"}, 32'(e), 32'h0);
    endtask

    function automatic logic [31:0] lane_merge(input logic [31:0] old_v,
                                               input logic [31:0] new_v,
                                               input logic [3:0] s);
        logic [31:0] mask;
        mask = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
        return (old_v & ~mask) | (new_v & mask);
    endfunction

    function automatic logic [31:0] with_upper(input logic [4:0] off);
        logic [31:0] r;
        r = $urandom();
        return {r[31:5], off};
    endfunction

    // Timer value in the cycle that follows 'now' clock edges.
    function automatic logic [31:0] model_count(input int now);
        int k;
        int ld;
        if (!m_running) return m_count_static;
        k  = now - m_start;
        ld = int'(m_load);
        if (m_reload) return 32'(ld - (k % (ld + 1)));
        if (k >= ld) return 32'h0;
        return 32'(ld - k);
    endfunction

    function automatic bit model_exp(input int now);
        return m_exp_static || (m_running && (now - m_start) >= int'(m_load) + 1);
    endfunction

    function automatic bit model_en(input int now);
        if (!m_running) return 1'b0;
        return m_reload || ((now - m_start) < int'(m_load) + 1);
    endfunction

    function automatic logic [31:0] model_ctrl(input int now);
        return {29'h0, m_irq_en, m_reload, model_en(now)};
    endfunction

    function automatic logic [31:0] model_irq(input int now);
        return 32'(m_irq_en && model_exp(now - 1));
    endfunction

    task automatic model_start(input logic [2:0] cf);
        m_irq_en  = cf[2];
        m_reload  = cf[1];
        m_running = cf[0];
        m_start   = cyc;
    endtask

    task automatic model_stop();
        m_count_static = model_count(cyc);
        m_exp_static   = model_exp(cyc);
        m_running      = 1'b0;
        m_reload       = 1'b0;
        m_irq_en       = 1'b0;
    endtask

    task automatic model_reset();
        m_load         = 32'h0;
        m_count_static = 32'h0;
        m_running      = 1'b0;
        m_reload       = 1'b0;
        m_irq_en       = 1'b0;
        m_exp_static   = 1'b0;
        m_start        = 0;
    endtask

    // Stop the timer and clear EXP so each scenario starts clean.
    task automatic stop_and_clear(input string tag);
        logic [31:0] r;
        wr(A_CTRL, 32'h0, 4'hF, {tag, "_stop"});
        model_stop();
        wr(A_STATUS, 32'h1, 4'hF, {tag, "_w1c"});
        m_exp_static = 1'b0;
        rd(A_STATUS, r, {tag, "_rdstat"});
        checkOutput({tag, "_status_clear"}, r, 32'h0);
    endtask

    initial begin
        logic [31:0] rdat;
        logic [31:0] wd;
        logic [31:0] addr;
        logic        rerr;
        logic [3:0]  st;
        logic [2:0]  cf;
        bit          wsel;
        int          ld;
        int          gap;
        int          kind;

        model_reset();
        PRESET  = 1'b1;
        PSEL    = 1'b0;
        PENABLE = 1'b0;
        PWRITE  = 1'b0;
        PADDR   = 32'h0;
        PWDATA  = 32'h0;
        PSTRB   = 4'h0;
        #2;
        checkOutput("rst_pready", 32'(PREADY), 32'h0);
        checkOutput("rst_pslverr", 32'(PSLVERR), 32'h0);
        checkOutput("rst_prdata", PRDATA, 32'h0);
        checkOutput("rst_irq", 32'(irq), 32'h0);
        step();
        step();
        PRESET = 1'b0;
        step();

        // Register reset values
        for (int i = 0; i < 4; i++) begin
            rd(32'(i * 4), rdat, "rst_rd");
            checkOutput($sformatf("rst_reg_%0h", i * 4), rdat, 32'h0);
        end

        // LOAD write/read-back
        wr(A_LOAD, 32'h0000_00A5, 4'hF, "load_a5");
        m_load = 32'h0000_00A5;
        m_count_static = m_load;
        rd(A_LOAD, rdat, "rd_load_a5");
        checkOutput("load_a5_readback", rdat, 32'h0000_00A5);
        rd(A_COUNT, rdat, "rd_count_a5");
        checkOutput("count_copy_a5", rdat, model_count(last_sample));

        // Auto-reload with interrupt, watched cycle by cycle
        wr(A_LOAD, 32'd3, 4'hF, "load3");
        m_load = 32'd3;
        m_count_static = m_load;
        wr(A_CTRL, 32'h7, 4'hF, "ctrl7");
        model_start(3'b111);
        for (int i = 0; i < 10; i++) begin
            checkOutput($sformatf("irq_cyc%0d", i), 32'(irq), model_irq(cyc));
            step();
        end
        for (int i = 0; i < 3; i++) begin
            rd(A_COUNT, rdat, "reload_rdcnt");
            checkOutput("reload_count", rdat, model_count(last_sample));
            rd(A_STATUS, rdat, "reload_rdstat");
            checkOutput("reload_status", rdat, 32'(model_exp(last_sample)));
        end
        stop_and_clear("reload");
        checkOutput("irq_after_clear", 32'(irq), 32'h0);

        // One-shot: EN self-clears, COUNT parks at zero, no interrupt
        wr(A_LOAD, 32'd2, 4'hF, "load2");
        m_load = 32'd2;
        m_count_static = m_load;
        wr(A_CTRL, 32'h1, 4'hF, "ctrl1");
        model_start(3'b001);
        repeat (10) step();
        rd(A_CTRL, rdat, "oneshot_rdctrl");
        checkOutput("oneshot_ctrl", rdat, 32'h0);
        rd(A_COUNT, rdat, "oneshot_rdcnt");
        checkOutput("oneshot_count", rdat, 32'h0);
        rd(A_STATUS, rdat, "oneshot_rdstat");
        checkOutput("oneshot_status", rdat, 32'h1);
        checkOutput("oneshot_irq", 32'(irq), 32'h0);
        stop_and_clear("oneshot");

        // Illegal accesses
        wr(A_LOAD, 32'h55, 4'hF, "load55");
        m_load = 32'h55;
        m_count_static = m_load;
        applyStimulus(1'b1, A_COUNT, 32'h1234, 4'hF, rdat, rerr);
        checkOutput("err_wr_count", 32'(rerr), 32'h1);
        applyStimulus(1'b0, 32'h14, 32'h0, 4'h0, rdat, rerr);
        checkOutput("err_rd_14", 32'(rerr), 32'h1);
        checkOutput("err_rd_14_data", rdat, 32'h0);
        applyStimulus(1'b0, 32'h06, 32'h0, 4'h0, rdat, rerr);
        checkOutput("err_rd_06", 32'(rerr), 32'h1);
        checkOutput("err_rd_06_data", rdat, 32'h0);
        applyStimulus(1'b1, 32'h06, 32'hFFFF_FFFF, 4'hF, rdat, rerr);
        checkOutput("err_wr_06", 32'(rerr), 32'h1);
        for (int i = 0; i < 8; i++) begin
            kind = $urandom_range(0, 3);
            wsel = 1'b0;
            case (kind)
                0: begin addr = with_upper(5'h08); wsel = 1'b1; end
                1: addr = with_upper(5'h14);
                2: addr = with_upper(5'h18 + 5'(4 * $urandom_range(0, 1)));
                default: begin
                    addr = with_upper({3'($urandom_range(0, 3)), 2'($urandom_range(1, 3))});
                    wsel = 1'($urandom_range(0, 1));
                end
            endcase
            applyStimulus(wsel, addr, $urandom(), 4'hF, rdat, rerr);
            checkOutput($sformatf("err_rand_%08h", addr), 32'(rerr), 32'h1);
            checkOutput("err_rand_data", rdat, 32'h0);
        end
        rd(A_LOAD, rdat, "err_rdload");
        checkOutput("err_load_kept", rdat, m_load);
        rd(A_COUNT, rdat, "err_rdcnt");
        checkOutput("err_count_kept", rdat, model_count(last_sample));
        rd(A_CTRL, rdat, "err_rdctrl");
        checkOutput("err_ctrl_kept", rdat, model_ctrl(last_sample));

        // Byte-lane writes to LOAD
        wr(A_LOAD, 32'h0, 4'hF, "load0");
        m_load = 32'h0;
        wr(A_LOAD, 32'hDEAD_BEEF, 4'b0010, "strb_lane1");
        m_load = lane_merge(m_load, 32'hDEAD_BEEF, 4'b0010);
        m_count_static = m_load;
        rd(A_LOAD, rdat, "strb_rdload");
        checkOutput("strb_load", rdat, 32'h0000_BE00);
        rd(A_COUNT, rdat, "strb_rdcnt");
        checkOutput("strb_count", rdat, m_load);
        for (int i = 0; i < 6; i++) begin
            wd = $urandom();
            st = 4'($urandom_range(0, 15));
            wr(with_upper(5'h04), wd, st, "rstrb");
            m_load = lane_merge(m_load, wd, st);
            m_count_static = m_load;
            rd(A_LOAD, rdat, "rstrb_rdload");
            checkOutput($sformatf("rstrb_load_s%0h", st), rdat, m_load);
            rd(A_COUNT, rdat, "rstrb_rdcnt");
            checkOutput("rstrb_count", rdat, m_load);
        end

        // Randomised timer runs sampled at random offsets
        for (int seg = 0; seg < 8; seg++) begin
            ld = $urandom_range(1, 12);
            cf = {1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1};
            wr(A_LOAD, 32'(ld), 4'hF, "seg_load");
            m_load = 32'(ld);
            m_count_static = m_load;
            wr(A_CTRL, 32'(cf), 4'hF, "seg_ctrl");
            model_start(cf);
            for (int j = 0; j < 4; j++) begin
                gap = $urandom_range(0, 9);
                repeat (gap) step();
                rd(with_upper(5'h08), rdat, "seg_rdcnt");
                checkOutput($sformatf("seg%0d_count_ld%0d_cf%0d", seg, ld, cf), rdat,
                            model_count(last_sample));
                rd(with_upper(5'h0C), rdat, "seg_rdstat");
                checkOutput($sformatf("seg%0d_status", seg), rdat, 32'(model_exp(last_sample)));
                rd(with_upper(5'h00), rdat, "seg_rdctrl");
                checkOutput($sformatf("seg%0d_ctrl", seg), rdat, model_ctrl(last_sample));
                checkOutput($sformatf("seg%0d_irq", seg), 32'(irq), model_irq(cyc));
            end
            stop_and_clear("seg");
        end

        // Reset arriving in the completion cycle of a LOAD write
        PSEL    = 1'b1;
        PENABLE = 1'b0;
        PWRITE  = 1'b1;
        PADDR   = A_LOAD;
        PWDATA  = 32'hCAFE_F00D;
        PSTRB   = 4'hF;
        step();
        PENABLE = 1'b1;
        #1;
        for (int i = 0; i < WS; i++) step();
        checkOutput("pre_rst_pready", 32'(PREADY), 32'h1);
        PRESET = 1'b1;
        #1;
        checkOutput("rst_mid_pready", 32'(PREADY), 32'h0);
        PSEL    = 1'b0;
        PENABLE = 1'b0;
        PWRITE  = 1'b0;
        step();
        step();
        PRESET = 1'b0;
        model_reset();
        step();
        rd(A_LOAD, rdat, "post_rst_rdload");
        checkOutput("post_rst_load", rdat, m_load);
        rd(A_COUNT, rdat, "post_rst_rdcnt");
        checkOutput("post_rst_count", rdat, model_count(last_sample));
        rd(A_CTRL, rdat, "post_rst_rdctrl");
        checkOutput("post_rst_ctrl", rdat, 32'h0);
        checkOutput("post_rst_irq", 32'(irq), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
